angle_radian_conv: RTL and testbench

ANGLE_RADIAN_CONV -- requirements
Module: angle_radian_conv

---
 rtl/angle_radian_conv.sv | 73 +++++++
 tb/tb_angle_radian_conv.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/angle_radian_conv.sv
// Degree <-> radian converter, two independent 2-stage pipelines.
// Degrees are unsigned integers; radians are unsigned Q16.16.
module angle_radian_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  deg_in,
  input  logic        deg_in_valid,
  output logic [31:0] rad_out,
  output logic        rad_out_valid,
  input  logic [31:0] rad_in,
  input  logic        rad_in_valid,
  output logic [8:0]  deg_out,
  output logic        deg_out_valid
);

  // round(pi/180 * 2^32) and round(180/pi * 2^16)
  localparam logic [36:0] D2R_K   = 37'd74961321;
  localparam logic [53:0] R2D_K   = 54'd3754936;
  localparam logic [36:0] D2R_RND = 37'd32768;
  localparam logic [53:0] R2D_RND = 54'h0000_8000_0000;
  localparam logic [21:0] DEG_MAX = 22'd511;

  logic [36:0] d_prod;
  logic        d_vld;
  logic [53:0] r_prod;
  logic        r_vld;

  logic [36:0] d_sum;
  logic [53:0] r_sum;
  logic [21:0] r_deg;

  // Round-half-up and saturate on the registered products
  always_comb begin
    d_sum = d_prod + D2R_RND;
    r_sum = r_prod + R2D_RND;
    r_deg = 22'(r_sum >> 32);
  end

  // Stage 1: register the constant products alongside their valids
  always_ff @(posedge clk) begin
    if (rst) begin
      d_prod <= '0;
      d_vld  <= 1'b0;
      r_prod <= '0;
      r_vld  <= 1'b0;
    end else begin
      d_vld <= deg_in_valid;
      r_vld <= rad_in_valid;
      if (deg_in_valid)
        d_prod <= 37'(deg_in) * D2R_K;
      if (rad_in_valid)
        r_prod <= 54'(rad_in) * R2D_K;
    end
  end

  // Stage 2: register rounded results; data holds when no valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_out       <= '0;
      rad_out_valid <= 1'b0;
      deg_out       <= '0;
      deg_out_valid <= 1'b0;
    end else begin
      rad_out_valid <= d_vld;
      deg_out_valid <= r_vld;
      if (d_vld)
        rad_out <= 32'(d_sum >> 16);
      if (r_vld)
        deg_out <= (r_deg > DEG_MAX) ? 9'd511 : r_deg[8:0];
    end
  end

endmodule

// File: tb/tb_angle_radian_conv.sv
// Scoreboard bench for angle_radian_conv.
// Driver queues per-cycle stimulus with expected results; monitor checks.
module tb_angle_radian_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  deg_in = '0;
  logic        deg_in_valid = 1'b0;
  logic [31:0] rad_out;
  logic        rad_out_valid;
  logic [31:0] rad_in = '0;
  logic        rad_in_valid = 1'b0;
  logic [8:0]  deg_out;
  logic        deg_out_valid;

  always #5 clk = ~clk;

  angle_radian_conv dut (
    .clk           (clk),
    .rst           (rst),
    .deg_in        (deg_in),
    .deg_in_valid  (deg_in_valid),
    .rad_out       (rad_out),
    .rad_out_valid (rad_out_valid),
    .rad_in        (rad_in),
    .rad_in_valid  (rad_in_valid),
    .deg_out       (deg_out),
    .deg_out_valid (deg_out_valid)
  );

  typedef struct {
    logic        rst;
    logic        dv;
    logic [31:0] rexp;
    logic        rv;
    logic [8:0]  dexp;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] d2r(input logic [8:0] d);
    longint unsigned p;
    p = (longint'(d) * 74961321 + 32768) / 65536;
    return 32'(p);
  endfunction

  function automatic logic [8:0] r2d(input logic [31:0] r);
    longint unsigned p;
    p = (longint'(r) * 3754936 + 64'd2147483648) / 64'd4294967296;
    return (p > 511) ? 9'd511 : 9'(p);
  endfunction

  task automatic step(input logic r, input logic dv,
                      input logic [8:0] d, input logic rv,
                      input logic [31:0] ri, input logic [8:0] dexp);
    rec_t e;
    @(negedge clk);
    rst          = r;
    deg_in_valid = dv;
    deg_in       = d;
    rad_in_valid = rv;
    rad_in       = ri;
    e.rst  = r;
    e.dv   = dv;
    e.rexp = d2r(d);
    e.rv   = rv;
    e.dexp = dexp;
    q.push_back(e);
  endtask

  task automatic norm(input logic r, input logic dv,
                      input logic [8:0] d, input logic rv,
                      input logic [31:0] ri);
    step(r, dv, d, rv, ri, r2d(ri));
  endtask

  task automatic idle();
    norm(1'b0, 1'b0, 9'd0, 1'b0, 32'd0);
  endtask

  // Monitor: output after edge k reflects the sample of edge k-1
  initial begin
    rec_t        cur;
    rec_t        prev;
    logic        have_prev;
    logic        ev_r;
    logic        ev_d;
    logic [31:0] held_r;
    logic [8:0]  held_d;
    have_prev = 1'b0;
    held_r = '0;
    held_d = '0;
    forever begin
      @(posedge clk);
      if (q.size() == 0) continue;
      cur = q.pop_front();
      #1;
      ev_r = 1'b0;
      ev_d = 1'b0;
      if (cur.rst) begin
        held_r = '0;
        held_d = '0;
      end else if (have_prev && !prev.rst) begin
        ev_r = prev.dv;
        ev_d = prev.rv;
        if (prev.dv) held_r = prev.rexp;
        if (prev.rv) held_d = prev.dexp;
      end
      n_cmp++;
      if (rad_out_valid !== ev_r || rad_out !== held_r) begin
        n_bad++;
        $display("FAIL d2r t=%0t: got v=%b d=%0d, want v=%b d=%0d",
                 $time, rad_out_valid, rad_out, ev_r, held_r);
      end
      n_cmp++;
      if (deg_out_valid !== ev_d || deg_out !== held_d) begin
        n_bad++;
        $display("FAIL r2d t=%0t: got v=%b d=%0d, want v=%b d=%0d",
                 $time, deg_out_valid, deg_out, ev_d, held_d);
      end
      prev = cur;
      have_prev = 1'b1;
    end
  end

  initial begin
    logic [8:0]  dd[5];
    logic [31:0] rr[5];
    dd = '{9'd0, 9'd90, 9'd180, 9'd360, 9'd511};
    rr = '{32'd0, 32'd102944, 32'd411775, 32'hFFFF_FFFF, 32'd205887};

    repeat (3) norm(1'b1, 1'b1, 9'd45, 1'b1, 32'd5000);
    idle();

    for (int i = 0; i < 5; i++)
      norm(1'b0, 1'b1, dd[i], 1'b1, rr[i]);
    repeat (3) idle();

    norm(1'b0, 1'b1, 9'd30, 1'b1, 32'd34315);
    idle();
    norm(1'b0, 1'b1, 9'd270, 1'b1, 32'd308832);
    repeat (3) idle();

    for (int i = 0; i < 10; i++)
      norm(1'b0, 1'b1, 9'($urandom_range(511)),
           1'b1, $urandom);
    repeat (3) idle();

    for (int d = 0; d <= 360; d++)
      step(1'b0, 1'b1, 9'(d), 1'b1, d2r(9'(d)), 9'(d));
    repeat (3) idle();

    norm(1'b0, 1'b1, 9'd123, 1'b1, 32'd99999);
    norm(1'b1, 1'b1, 9'd200, 1'b1, 32'd77777);
    norm(1'b1, 1'b1, 9'd201, 1'b1, 32'd77778);
    norm(1'b0, 1'b1, 9'd77, 1'b1, 32'd600000);
    repeat (3) idle();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ri;
      ri = ($urandom_range(1) == 1) ? $urandom
                                    : 32'($urandom_range(700000));
      norm(($urandom_range(29) == 0),
           ($urandom_range(3) != 0), 9'($urandom_range(511)),
           ($urandom_range(3) != 0), ri);
    end
    repeat (3) idle();

    @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
